// File: rtl/sum_tree_scheduler.sv
// Round-robin scheduler that shares one fixed-latency float32 adder tree among
// several clients and tags each returning sum with the requester that owns it.
module sum_tree_scheduler #(
    parameter int BITWIDTH     = 32,
    parameter int VALUES       = 3,
    parameter int REQUESTERS   = 4,
    parameter int TREE_LATENCY = 2,
    parameter int ID_W         = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [REQUESTERS-1:0]                  req_valid,
    input  logic [REQUESTERS*VALUES*BITWIDTH-1:0]  req_data,
    output logic [REQUESTERS-1:0]                  req_ready,
    input  logic                                   hold,
    output logic [VALUES*BITWIDTH-1:0]             tree_data,
    input  logic [BITWIDTH-1:0]                    tree_result,
    output logic                                   res_valid,
    output logic [ID_W-1:0]                        res_id,
    output logic [BITWIDTH-1:0]                    res_data,
    output logic                                   busy
);

    localparam int VW     = VALUES * BITWIDTH;
    localparam int STAGES = TREE_LATENCY + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [VW-1:0]   vec [REQUESTERS];
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic [VW-1:0]   tree_data_q, tree_data_d;
    tag_t            tag_d;
    tag_t            shadow_q [STAGES];
    logic            res_valid_q;
    logic [ID_W-1:0] res_id_q;
    logic [BITWIDTH-1:0] res_data_q;

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
        assign vec[g] = req_data[g*VW +: VW];
    end

    // Scan from the client after the last winner; the first valid one wins.
    always_comb begin
        // NOTE: every variable gets a default before the scan so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int off = 1; off <= REQUESTERS; off++) begin
            cand = ID_W'((int'(ptr_q) + off) % REQUESTERS);
            if (!gnt_any && !hold && !rst && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign ptr_d       = gnt_any ? gnt_id : ptr_q;
    assign tree_data_d = gnt_any ? vec[gnt_id] : '0;
    assign tag_d.valid = gnt_any;
    assign tag_d.id    = gnt_any ? gnt_id : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= ID_W'(REQUESTERS - 1);
            tree_data_q <= '0;
            // NOTE: the shadow tags must be cleared on reset, unlike a data-only
            // delay line; stale valid bits would emit results nobody issued.
            for (int s = 0; s < STAGES; s++) begin
                shadow_q[s] <= '0;
            end
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift from the
            // previous cycle's values regardless of statement order.
            ptr_q       <= ptr_d;
            tree_data_q <= tree_data_d;
            shadow_q[0] <= tag_d;
            for (int s = 1; s < STAGES; s++) begin
                shadow_q[s] <= shadow_q[s-1];
            end
            res_valid_q <= shadow_q[STAGES-1].valid;
            res_id_q    <= shadow_q[STAGES-1].id;
            res_data_q  <= tree_result;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy = busy | shadow_q[s].valid;
        end
    end

    assign tree_data = tree_data_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_sum_tree_scheduler.sv
// Bench for sum_tree_scheduler: models the adder tree on integer-valued floats and
// scores grants, issue data, busy and tagged results against a transaction model.
module tb_sum_tree_scheduler;

    localparam int BW  = 32;
    localparam int NV  = 3;
    localparam int NR  = 4;
    localparam int TL  = 2;
    localparam int IDW = 2;
    localparam int VW  = NV * BW;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR*VW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               hold;
    logic [VW-1:0]      tree_data;
    logic [BW-1:0]      tree_result;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [BW-1:0]      res_data;
    logic               busy;

    sum_tree_scheduler #(
        .BITWIDTH(BW), .VALUES(NV), .REQUESTERS(NR), .TREE_LATENCY(TL), .ID_W(IDW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .hold(hold), .tree_data(tree_data),
        .tree_result(tree_result), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only non-negative integers below 2^24 are used, so conversion is exact.
    function automatic int f2i(input logic [31:0] b);
        int e;
        logic [31:0] m;
        if (b[30:0] == 31'd0) return 0;
        e = int'(b[30:23]);
        m = {8'd1, b[22:0]};
        return int'(m >> (150 - e));
    endfunction

    function automatic logic [31:0] i2f(input int v);
        int p;
        logic [31:0] u, sh;
        if (v == 0) return 32'd0;
        u = v;
        p = 0;
        for (int i = 0; i < 32; i++) if (u[i]) p = i;
        sh = u << (23 - p);
        return {1'b0, 8'(127 + p), sh[22:0]};
    endfunction

    logic [31:0] t_q [TL];
    always @(posedge clk) begin
        t_q[0] <= i2f(f2i(tree_data[31:0]) + f2i(tree_data[63:32]) + f2i(tree_data[95:64]));
        for (int s = 1; s < TL; s++) t_q[s] <= t_q[s-1];
    end
    assign tree_result = t_q[TL-1];

    typedef struct {
        int acc;
        int id;
        int sum;
    } item_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic          hold;
        logic [NR-1:0] exp_ready;
    } vec_t;

    item_t         sb[$];
    int            got[$];
    int            vals [NR][NV];
    int            m_ptr;
    int            cyc;
    int            last_grant;
    logic [VW-1:0] exp_tree;
    logic [NR-1:0] smp_ready;
    int            n_chk;
    int            n_fail;
    int            lat;
    vec_t          tbl [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_vec(input int c, input int a, input int b, input int d);
        vals[c][0] = a;
        vals[c][1] = b;
        vals[c][2] = d;
        for (int j = 0; j < NV; j++) req_data[c*VW + j*BW +: BW] = i2f(vals[c][j]);
    endtask

    task automatic rand_vec(input int c);
        set_vec(c, int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)),
                int'($urandom_range(0, 1000)));
    endtask

    function automatic int vsum(input int c);
        return vals[c][0] + vals[c][1] + vals[c][2];
    endfunction

    function automatic int exp_grant();
        int c;
        if (rst || hold) return -1;
        for (int off = 1; off <= NR; off++) begin
            c = (m_ptr + off) % NR;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: compare at the falling edge, advance the model, then
    // return 1 time unit after the rising edge with inputs free to change.
    task automatic step();
        int g;
        logic exp_busy;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            m_ptr    = NR - 1;
            exp_tree = '0;
        end
        g = exp_grant();
        smp_ready = req_ready;
        check("req_ready", req_ready, (g < 0) ? 128'd0 : (128'd1 << g));
        check("tree_data", tree_data, exp_tree);
        exp_busy = 1'b0;
        foreach (sb[i]) if (sb[i].acc + TL + 1 > cyc) exp_busy = 1'b1;
        check("busy", busy, exp_busy);
        if (sb.size() > 0 && sb[0].acc + TL + 1 == cyc) begin
            check("res_valid", res_valid, 1'b1);
            check("res_id", res_id, sb[0].id);
            check("res_data", res_data, i2f(sb[0].sum));
            void'(sb.pop_front());
        end else begin
            check("res_valid", res_valid, 1'b0);
        end
        if (res_valid === 1'b1) got.push_back(int'(res_id));
        last_grant = g;
        if (g >= 0) begin
            sb.push_back('{acc: cyc + 1, id: g, sum: vsum(g)});
            m_ptr    = g;
            exp_tree = req_data[g*VW +: VW];
        end else begin
            exp_tree = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; last_grant = -1;
        m_ptr = NR - 1; exp_tree = '0;
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_data = '0;
        for (int c = 0; c < NR; c++) rand_vec(c);

        tbl[0]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b1010, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1010, 1'b0, 4'b1000};
        tbl[3]  = '{4'b0110, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0110, 1'b0, 4'b0010};
        tbl[5]  = '{4'b0011, 1'b0, 4'b0001};
        tbl[6]  = '{4'b0001, 1'b0, 4'b0001};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0101, 1'b0, 4'b0100};
        tbl[10] = '{4'b1011, 1'b0, 4'b1000};

        // Reset state
        step();
        step();
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_id", res_id, 2'd0);
        check("rst_tree_data", tree_data, 96'd0);
        rst = 1'b0;

        // T1: single vector from client 2
        set_vec(2, 1, 2, 3);
        check("t1_vec_encoding", req_data[2*VW +: VW], 96'h40400000_40000000_3F800000);
        req_valid = 4'b0100;
        step();
        check("t1_grant", last_grant, 2);
        req_valid = '0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        check("t1_latency", lat, TL + 1);
        check("t1_res_id", res_id, 2'd2);
        check("t1_res_data", res_data, 32'h40C00000);
        step();

        // Arbitration table from a fresh pointer
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].valid;
            hold      = tbl[i].hold;
            step();
            check("tbl_ready", smp_ready, tbl[i].exp_ready);
        end
        req_valid = '0; hold = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // T2: fairness with all clients requesting
        do_reset();
        got.delete();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_grant", last_grant, i % NR);
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        check("t2_count", got.size(), 8);
        foreach (got[i]) check("t2_res_order", got[i], i % NR);

        // T3: hold while requests are pending, in-flight results drain
        do_reset();
        got.delete();
        req_valid = 4'b0011;
        step();
        step();
        hold = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_ready", smp_ready, 4'b0000);
        end
        check("t3_count", got.size(), 2);
        check("t3_busy", busy, 1'b0);
        hold = 1'b0;
        req_valid = '0;

        // T4: bubbles from a client valid every other cycle
        do_reset();
        got.delete();
        for (int i = 0; i < 8; i++) begin
            req_valid = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            if (i % 2 == 0) rand_vec(1);
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        check("t4_count", got.size(), 4);

        // T5: reset pulse right after three accepts
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) step();
        req_valid = '0;
        got.delete();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        check("t5_no_results", got.size(), 0);
        req_valid = 4'b1111;
        step();
        check("t5_first_grant", last_grant, 0);
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();

        // T6: lone requester
        got.delete();
        for (int i = 0; i < 5; i++) begin
            set_vec(3, 10*i + 1, 10*i + 2, 10*i + 3);
            req_valid = 4'b1000;
            step();
            check("t6_grant", last_grant, 3);
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        check("t6_count", got.size(), 5);
        foreach (got[i]) check("t6_res_id", got[i], 3);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NR; c++) begin
                if (!req_valid[c] || c == last_grant) rand_vec(c);
            end
            req_valid = NR'($urandom);
            hold      = ($urandom_range(0, 7) == 0);
            step();
        end
        req_valid = '0;
        hold = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("final_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
